adsr_envelope: RTL
==================

Name: adsr_envelope

Overview:
- Amplitude-envelope stage between the sine wavetable BRAM read port and the PWM driver.
- Takes the raw unsigned 8-bit wavetable sample and a note gate. Runs an Attack/Decay/Sustain/Release state machine on a divided tick.
- Scales the sample about mid-scale (128) by the current envelope and outputs an unsigned 8-bit sample.
- Notes fade in and out instead of clicking on and off.

Parameters:
- SAMPLE_WIDTH, 8: width of sample_in and sample_out (unsigned, mid-scale 2^(SAMPLE_WIDTH-1)).
- ENV_WIDTH, 16: envelope accumulator width; full scale is 2^ENV_WIDTH-1.
- TICK_DIV, 100_000: clk_in cycles per envelope update (1 kHz at 100 MHz); must be ≥2.

Ports:
- clk_in  input  1  system clock (100 MHz).
- rst_in  input  1  reset, synchronous, active-low.
- gate_in  input  1  note held (1) / released (0).
- attack_step_in  input  ENV_WIDTH  env increment per tick in ATTACK.
- decay_step_in  input  ENV_WIDTH  env decrement per tick in DECAY.
- sustain_level_in  input  8  sustain target; expands to {sustain,sustain} in 16 bits.
- release_step_in  input  ENV_WIDTH  env decrement per tick in RELEASE.
- sample_in  input  SAMPLE_WIDTH  unsigned wavetable sample, valid every cycle.
- sample_out  output  SAMPLE_WIDTH  envelope-scaled unsigned sample, to PWM.
- env_out  output  ENV_WIDTH  current envelope value.
- state_out  output  3  IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- active_out  output  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (rst_in low at clk_in edge): state IDLE, env 0, tick counter 0, gate_q 0, sample_out 128, env_out 0, active_out 0.
- Reset asserted mid-note forces IDLE on that edge; no release tail.
- Tick counter:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high for one cycle when count == TICK_DIV-1.
  - Free-running; never restarted by gate edges.
- Gate edges:
  - gate_q is gate_in registered.
  - Rise = gate_in & ~gate_q; fall = ~gate_in & gate_q.
  - Edges act on the cycle they are detected, independent of tick.
- Transitions (edge has priority over tick; no env update on a cycle with an edge):
  - Any state + rise → ATTACK. Retrigger keeps the current env; it is not reset to 0.
  - ATTACK/DECAY/SUSTAIN + fall → RELEASE.
  - ATTACK, tick: env = min(env + attack_step, 0xFFFF), using a 17-bit sum. If the result is 0xFFFF → DECAY. attack_step 0 sets env to 0xFFFF.
  - DECAY, tick: env = max(env − decay_step, S), where S = {sustain,sustain}. If the result is S → SUSTAIN. decay_step 0 sets env to S.
  - SUSTAIN: env tracks S live every cycle; holds until fall.
  - RELEASE, tick: env = max(env − release_step, 0). If the result is 0 → IDLE. release_step 0 sets env to 0.
  - IDLE: env held at 0.
- Scaling pipeline, 2-cycle latency from sample_in to sample_out:
  - Stage 1 registers d = signed 9-bit (sample_in − 128) and e = env[15:8].
  - Stage 2 computes p = d × {1'b0,e} (signed 18-bit) and registers sample_out = 128 + (p >>> 8), truncated to 8 bits.
  - Range proof: for d = −128 and e = 255 the result is 0; for d = 127 and e = 255 it is 254. No overflow.
  - env = 0 gives sample_out exactly 128.
- env_out, state_out, active_out are registered, with 0-cycle latency relative to the internal state registers.

Optional Feature:
- Macro: ADSR_EXP_RELEASE_EN.
- Defined: the RELEASE tick computes env = env − (env >> 4) − 1, saturating at 0, for an exponential tail. release_step_in is ignored. Exit to IDLE when env reaches 0.
- Undefined: linear release exactly as specified in Behaviour.

Test Plan:
- Reset release: hold rst_in low 3 cycles then release, gate 0, sample_in 255 → sample_out 128, env_out 0, state_out 0, active_out 0.
- Full ADSR (TICK_DIV=4):
  - Setup: attack 0x4000, decay 0x1000, sustain 0x80, release 0x2000, sample_in 255.
  - Gate 1 → ATTACK; env 0x4000, 0x8000, 0xC000, 0xFFFF on successive ticks, then DECAY.
  - Decay runs to 0x8080 and enters SUSTAIN.
  - Sample path: sample_out = 128 + ((127 × 128) >>> 8) = 191, two cycles after env_out shows 0x80xx.
  - Gate 0 → RELEASE next cycle; env falls by 0x2000 per tick to 0, then IDLE and active_out 0.
- Retrigger: gate falls at env 0x6000, then rises again before IDLE → ATTACK resumes from the decayed env, not from 0.
- Edge/tick collision: gate rise on the same cycle as tick → state ATTACK, env unchanged that cycle.
- Zero steps: attack_step 0 → env 0xFFFF after one tick; decay_step 0 → env = S after one tick.
- Mid-note reset: rst_in low while in SUSTAIN → IDLE, env 0, sample_out 128 on the next cycle. With ADSR_EXP_RELEASE_EN, release from 0xFFFF follows 0xEFFF, 0xE0FF, ...

Source files
------------

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven A/D/S/R state machine on a divided tick,
// scaling the wavetable sample about mid-scale. ADSR_EXP_RELEASE_EN selects an exponential release tail.
module adsr_envelope #(
  parameter int SAMPLE_WIDTH = 8,
  parameter int ENV_WIDTH    = 16,
  parameter int TICK_DIV     = 100_000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    gate_in,
  input  logic [ENV_WIDTH-1:0]    attack_step_in,
  input  logic [ENV_WIDTH-1:0]    decay_step_in,
  input  logic [7:0]              sustain_level_in,
  input  logic [ENV_WIDTH-1:0]    release_step_in,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  output logic [SAMPLE_WIDTH-1:0] sample_out,
  output logic [ENV_WIDTH-1:0]    env_out,
  output logic [2:0]              state_out,
  output logic                    active_out
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [ENV_WIDTH-1:0]    ENV_MAX = '1;
  localparam logic [SAMPLE_WIDTH-1:0] MID     = SAMPLE_WIDTH'(1 << (SAMPLE_WIDTH - 1));

  state_t               state;
  logic [ENV_WIDTH-1:0] env;
  logic [CNT_W-1:0]     tick_cnt;
  logic                 gate_q;
  logic                 tick, rise, fall;
  logic [ENV_WIDTH-1:0] sus_lvl;
  logic [ENV_WIDTH:0]   att_sum, dec_diff, rel_diff;
  logic [ENV_WIDTH-1:0] att_next, dec_next, rel_next;

  assign tick    = (tick_cnt == CNT_W'(TICK_DIV - 1));
  assign rise    = gate_in & ~gate_q;
  assign fall    = ~gate_in & gate_q;
  assign sus_lvl = ENV_WIDTH'({sustain_level_in, sustain_level_in});

  // Saturating step arithmetic; one extra bit catches overflow/underflow.
  assign att_sum  = {1'b0, env} + {1'b0, attack_step_in};
  assign dec_diff = {1'b0, env} - {1'b0, decay_step_in};
  assign att_next = (att_sum[ENV_WIDTH] || attack_step_in == '0) ? ENV_MAX : att_sum[ENV_WIDTH-1:0];
  assign dec_next = (dec_diff[ENV_WIDTH] || decay_step_in == '0 || dec_diff[ENV_WIDTH-1:0] <= sus_lvl)
                    ? sus_lvl : dec_diff[ENV_WIDTH-1:0];

`ifdef ADSR_EXP_RELEASE_EN
  logic unused_release;
  assign unused_release = ^release_step_in;
  assign rel_diff = {1'b0, env} - {1'b0, (env >> 4)} - (ENV_WIDTH + 1)'(1);
  assign rel_next = rel_diff[ENV_WIDTH] ? '0 : rel_diff[ENV_WIDTH-1:0];
`else
  assign rel_diff = {1'b0, env} - {1'b0, release_step_in};
  assign rel_next = (rel_diff[ENV_WIDTH] || release_step_in == '0) ? '0 : rel_diff[ENV_WIDTH-1:0];
`endif

  // Gate edges take priority over the tick and suppress the env update on that cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state    <= ST_IDLE;
      env      <= '0;
      tick_cnt <= '0;
      gate_q   <= 1'b0;
    end else begin
      gate_q   <= gate_in;
      tick_cnt <= tick ? '0 : tick_cnt + CNT_W'(1);
      if (rise) begin
        state <= ST_ATTACK;
      end else if (fall) begin
        if (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN)
          state <= ST_RELEASE;
      end else begin
        case (state)
          ST_IDLE: env <= '0;
          ST_ATTACK: if (tick) begin
            env <= att_next;
            if (att_next == ENV_MAX) state <= ST_DECAY;
          end
          ST_DECAY: if (tick) begin
            env <= dec_next;
            if (dec_next == sus_lvl) state <= ST_SUSTAIN;
          end
          ST_SUSTAIN: env <= sus_lvl;
          ST_RELEASE: if (tick) begin
            env <= rel_next;
            if (rel_next == '0) state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
            env   <= '0;
          end
        endcase
      end
    end
  end

  logic signed [SAMPLE_WIDTH:0]   d_q;
  logic        [7:0]              e_q;
  logic signed [SAMPLE_WIDTH+9:0] prod;
  logic                           unused_prod;

  assign prod        = d_q * $signed({1'b0, e_q});
  assign unused_prod = ^{prod[SAMPLE_WIDTH+9:SAMPLE_WIDTH+8], prod[7:0]};

  // Two-stage scaler: centre the sample, then multiply by the envelope's top byte.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      d_q        <= '0;
      e_q        <= '0;
      sample_out <= MID;
    end else begin
      d_q        <= $signed({1'b0, sample_in} - {1'b0, MID});
      e_q        <= env[ENV_WIDTH-1 -: 8];
      sample_out <= MID + prod[SAMPLE_WIDTH+7:8];
    end
  end

  assign env_out    = env;
  assign state_out  = state;
  assign active_out = (state != ST_IDLE);

endmodule
